// File: rtl/dma_bridge_pkg.sv
// Shared definitions for the DMA-to-memory bridge: FSM encoding, default timeout
// and the latched request record.
package dma_bridge_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [7:0] WAIT_MAX_DEFAULT = 8'd32;

  typedef struct packed {
    logic [15:1] addr;
    logic [1:0]  we;
    logic [15:0] din;
  } dma_req_t;

  function automatic logic is_write(input logic [1:0] we);
    return we != 2'b00;
  endfunction

endpackage

// File: rtl/dma_sat_cnt.sv
// 8-bit up-counter that sticks at 8'hFF; clear has priority over increment.
module dma_sat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 8'h00;
    end else if (clr) begin
      count_reg <= 8'h00;
    end else if (inc && (count_reg != 8'hFF)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dma_mem_bridge.sv
// Bridges a single-beat DMA master onto a shared memory port that the CPU may
// hold off; gives up with an error response after WAIT_MAX ungranted cycles.
module dma_mem_bridge
  import dma_bridge_pkg::*;
#(
  parameter logic [7:0] WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        dma_en,
  input  logic [15:1] dma_addr,
  input  logic [1:0]  dma_we,
  input  logic [15:0] dma_din,
  output logic        dma_ready,
  output logic        dma_resp,
  output logic [15:0] dma_dout,
  output logic        mem_req,
  output logic [15:1] mem_addr,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_din,
  input  logic        mem_gnt,
  input  logic [15:0] mem_dout,
  output logic [7:0]  stall_cnt
);

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  dma_req_t    req_reg;
  logic [15:0] dout_reg;
  logic [7:0]  wait_cnt;

  logic in_req;
  logic accept;
  logic stall;
  logic timeout;

  assign in_req  = (state_reg == ST_REQ);
  assign accept  = (state_reg == ST_IDLE) && dma_en;
  assign stall   = in_req && !mem_gnt;
  assign timeout = stall && (wait_cnt == (WAIT_MAX - 8'd1));

  dma_sat_cnt u_wait_cnt (
    .clk   (mclk),
    .rst_n (puc_rst_n),
    .clr   (accept),
    .inc   (stall),
    .count (wait_cnt)
  );

  dma_sat_cnt u_stall_cnt (
    .clk   (mclk),
    .rst_n (puc_rst_n),
    .clr   (1'b0),
    .inc   (stall),
    .count (stall_cnt)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (dma_en) state_next = ST_REQ;
      ST_REQ: begin
        if (mem_gnt)      state_next = is_write(req_reg.we) ? ST_DONE : ST_RDATA;
        else if (timeout) state_next = ST_ERR;
      end
      ST_RDATA: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_reg <= ST_IDLE;
      req_reg   <= '0;
      dout_reg  <= 16'h0000;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        req_reg.addr <= dma_addr;
        req_reg.we   <= dma_we;
        req_reg.din  <= dma_din;
      end
      // Zeroing on the way into ERR makes the data already 0 while the error pulse is up.
      if (state_reg == ST_RDATA) begin
        dout_reg <= mem_dout;
      end else if (timeout) begin
        dout_reg <= 16'h0000;
      end
    end
  end

  assign mem_req   = in_req;
  assign mem_addr  = in_req ? req_reg.addr : 15'h0000;
  assign mem_we    = in_req ? req_reg.we   : 2'b00;
  assign mem_din   = in_req ? req_reg.din  : 16'h0000;
  assign dma_ready = (state_reg == ST_DONE) || (state_reg == ST_ERR);
  assign dma_resp  = (state_reg == ST_ERR);
  assign dma_dout  = dout_reg;

endmodule

// File: tb/tb_dma_mem_bridge.sv
// Randomized scoreboard bench for dma_mem_bridge: a memory responder grants after a
// planned delay, a monitor compares each completion against a transaction-level model.
module tb_dma_mem_bridge;

  localparam logic [7:0] WM = 8'd4;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        dma_en = 1'b0;
  logic [15:1] dma_addr = '0;
  logic [1:0]  dma_we = '0;
  logic [15:0] dma_din = '0;
  logic        dma_ready, dma_resp;
  logic [15:0] dma_dout;
  logic        mem_req;
  logic [15:1] mem_addr;
  logic [1:0]  mem_we;
  logic [15:0] mem_din;
  logic        mem_gnt = 1'b0;
  logic [15:0] mem_dout = '0;
  logic [7:0]  stall_cnt;

  dma_mem_bridge #(.WAIT_MAX(WM)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .dma_en(dma_en), .dma_addr(dma_addr),
    .dma_we(dma_we), .dma_din(dma_din), .dma_ready(dma_ready), .dma_resp(dma_resp),
    .dma_dout(dma_dout), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_gnt(mem_gnt), .mem_dout(mem_dout), .stall_cnt(stall_cnt)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [15:1] addr;
    logic [1:0]  we;
    logic [15:0] din;
    int          d;      // ungranted cycles before the grant
    logic [15:0] rdata;
  } plan_t;

  typedef struct {
    bit          err;
    logic [15:0] dout;
    int          stall;
    int          lat;    // first REQ cycle to ready cycle, inclusive
    bit          b2b;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, starts = 0, dones = 0, issued = 0, expected = 0;
  int start_cyc = 0, prev_ready = -100;
  int m_stall = 0;
  logic [15:0] m_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge mclk) cyc++;

  // Memory responder
  plan_t       cur;
  bit          active = 0;
  int          cnt = 0;
  bit          rd_pend = 0;
  logic [15:0] rd_val = '0;

  always @(negedge mclk) begin
    if (!puc_rst_n) begin
      active = 0; mem_gnt = 0; rd_pend = 0;
    end else begin
      mem_dout = rd_pend ? rd_val : 16'($urandom);
      rd_pend = 0;
      if (mem_req) begin
        if (!active) begin
          if (plan_q.size() == 0) begin
            check("spurious_req", 1, 0);
          end else begin
            cur = plan_q.pop_front();
            active = 1; cnt = 0; starts++; start_cyc = cyc;
          end
        end
        mem_gnt = 0;
        if (active) begin
          check("mem_addr", 32'(mem_addr), 32'(cur.addr));
          check("mem_we", 32'(mem_we), 32'(cur.we));
          check("mem_din", 32'(mem_din), 32'(cur.din));
          if (cnt == cur.d) begin
            mem_gnt = 1; active = 0;
            if (cur.we == 2'b00) begin rd_pend = 1; rd_val = cur.rdata; end
          end else begin
            cnt++;
          end
        end
      end else begin
        active = 0;
        mem_gnt = 1'($urandom);  // must be ignored outside REQ
      end
    end
  end

  // Completion monitor
  exp_t e;
  always @(negedge mclk) begin
    if (puc_rst_n) begin
      if (!mem_req)
        check("mem_idle_zero", {mem_addr, mem_we, mem_din}, 32'h0);
      if (dma_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("done #%0d resp=%0d dout=%h stall=%0d lat=%0d", dones, dma_resp, dma_dout, stall_cnt, cyc - start_cyc + 1);
          check("dma_resp", 32'(dma_resp), 32'(e.err));
          check("dma_dout", 32'(dma_dout), 32'(e.dout));
          check("stall_cnt", 32'(stall_cnt), e.stall);
          check("latency", cyc - start_cyc + 1, e.lat);
          if (e.b2b) check("b2b_gap", start_cyc - prev_ready, 2);
        end
        prev_ready = cyc;
        dones++;
      end
    end
  end

  task automatic tick;
    @(negedge mclk);
    #1;
  endtask

  function automatic plan_t mk(input logic [15:1] a, input logic [1:0] w, input logic [15:0] di,
                               input int d, input logic [15:0] rd);
    plan_t p;
    p.addr = a; p.we = w; p.din = di; p.d = d; p.rdata = rd;
    return p;
  endfunction

  function automatic plan_t mk_rand(input int dmax);
    return mk(15'($urandom), 2'($urandom), 16'($urandom), $urandom_range(0, dmax), 16'($urandom));
  endfunction

  task automatic issue(input plan_t p, input bit b2b, input bit expect_done);
    exp_t x;
    plan_q.push_back(p);
    if (expect_done) begin
      if (p.d >= int'(WM)) begin
        x.err = 1; m_dout = 16'h0000; m_stall += int'(WM); x.lat = int'(WM) + 1;
      end else begin
        x.err = 0; m_stall += p.d;
        if (p.we == 2'b00) begin m_dout = p.rdata; x.lat = p.d + 3; end
        else x.lat = p.d + 2;
      end
      if (m_stall > 255) m_stall = 255;
      x.dout = m_dout; x.stall = m_stall; x.b2b = b2b;
      exp_q.push_back(x);
      expected++;
    end
    dma_addr = p.addr; dma_we = p.we; dma_din = p.din; dma_en = 1'b1;
    issued++;
    for (int g = 0; g < 300 && starts < issued; g++) tick;
    if (starts < issued) check("start_timeout", starts, issued);
  endtask

  // Drop the strobe and scramble the inputs; the latched request must not follow them.
  task automatic release_en;
    dma_en = 1'b0;
    dma_addr = 15'($urandom); dma_we = 2'($urandom); dma_din = 16'($urandom);
  endtask

  task automatic wait_done;
    for (int g = 0; g < 500 && dones < expected; g++) tick;
    if (dones < expected) check("done_timeout", dones, expected);
  endtask

  initial begin
    repeat (3) tick;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_dma_ready", 32'(dma_ready), 0);
    check("rst_dma_resp", 32'(dma_resp), 0);
    check("rst_dma_dout", 32'(dma_dout), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_mem_fields", {mem_addr, mem_we, mem_din}, 0);
    puc_rst_n = 1'b1;
    tick;

    // Directed: immediate write, delayed read, timeout, back-to-back writes.
    issue(mk(15'h0100, 2'b11, 16'hBEEF, 0, 16'h0), 0, 1); release_en; wait_done;
    issue(mk(15'h0200, 2'b00, 16'h0000, 3, 16'h1234), 0, 1); release_en; wait_done;
    issue(mk(15'h0300, 2'b00, 16'h0000, 1000, 16'h5555), 0, 1); release_en; wait_done;
    issue(mk(15'h0400, 2'b01, 16'hA5A5, 0, 16'h0), 0, 1);
    issue(mk(15'h0401, 2'b10, 16'h5A5A, 0, 16'h0), 1, 1);
    release_en; wait_done;
    // Grant in the very last allowed cycle beats the timeout.
    issue(mk(15'h0500, 2'b00, 16'h0000, int'(WM) - 1, 16'hC0DE), 0, 1); release_en; wait_done;

    for (int i = 0; i < 60; i++) begin
      bit b2b;
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        release_en; wait_done;
        repeat ($urandom_range(0, 2)) tick;
      end
      issue(mk_rand(5), b2b, 1);
    end
    release_en; wait_done;

    // Saturation: 80 timeouts give 320 ungranted cycles.
    for (int i = 0; i < 80; i++) begin
      issue(mk(15'($urandom), 2'($urandom), 16'($urandom), 1000, 16'h0), 0, 1);
      release_en; wait_done;
    end
    check("stall_saturated", 32'(stall_cnt), 32'hFF);

    // Reset in the middle of a stall.
    issue(mk(15'h0777, 2'b00, 16'h0000, 1000, 16'h0), 0, 0);
    release_en;
    tick;
    check("pre_rst_mem_req", 32'(mem_req), 1);
    puc_rst_n = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 0);
    check("abort_stall_cnt", 32'(stall_cnt), 0);
    check("abort_dma_dout", 32'(dma_dout), 0);
    m_stall = 0; m_dout = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("abort_no_ready", 32'(dma_ready), 0);
    end
    puc_rst_n = 1'b1;
    issue(mk(15'h0123, 2'b11, 16'h4321, 0, 16'h0), 0, 1); release_en; wait_done;
    issue(mk(15'h0124, 2'b00, 16'h0000, 2, 16'h9876), 0, 1); release_en; wait_done;

    repeat (10) tick;
    check("exp_queue_empty", exp_q.size(), 0);
    check("plan_queue_empty", plan_q.size(), 0);
    check("done_count", dones, expected);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
